axis_perf_cnt: RTL and testbench

//   AXI-Stream pass-through monitor: forwards s_axis to m_axis unchanged and measures the stream.
//   - Measurement window opens on the first m-side beat and closes on the cnt_limit-th beat.
//   - Over the window it counts beats, elapsed cycles, backpressure cycles and starvation cycles.
//   - Sits on a link between two pipeline stages; a host reads the results once done=1.
//   - Optional register slice (REG_SLICE=1) breaks the ready/valid timing path.

---
 rtl/axis_perf_cnt_pkg.sv | 10 +
 rtl/axis_perf_cnt_skid_buffer.sv | 49 ++++
 rtl/axis_perf_cnt.sv | 98 +++++++++
 tb/tb_axis_perf_cnt.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_perf_cnt_pkg.sv
// Shared types for the AXI-Stream performance counter.
package axis_perf_cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/axis_perf_cnt_skid_buffer.sv
// Two-entry skid buffer: registered ready, one cycle latency, full throughput.
module axis_perf_cnt_skid_buffer #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic                  out_vld_p1;
    logic [DATA_WIDTH-1:0] out_data_p1;
    logic                  skid_vld_p0;
    logic [DATA_WIDTH-1:0] skid_data_p0;
    logic                  load_out;
    logic                  load_skid;

    // Input side: a beat that cannot advance to the output register parks in the skid entry
    assign load_out  = skid_vld_p0 ? m_ready : (!out_vld_p1 || m_ready);
    assign load_skid = !skid_vld_p0 && out_vld_p1 && !m_ready && s_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_p1  <= 1'b0;
            skid_vld_p0 <= 1'b0;
        end else if (skid_vld_p0) begin
            if (m_ready) skid_vld_p0 <= 1'b0;
        end else if (!out_vld_p1 || m_ready) begin
            out_vld_p1 <= s_valid;
        end else if (s_valid) begin
            skid_vld_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_out)  out_data_p1  <= skid_vld_p0 ? skid_data_p0 : s_data;
        if (load_skid) skid_data_p0 <= s_data;
    end

    // Output side
    assign s_ready = !skid_vld_p0;
    assign m_valid = out_vld_p1;
    assign m_data  = out_data_p1;

endmodule

// File: rtl/axis_perf_cnt.sv
// AXI-Stream pass-through monitor measuring beats, cycles, stalls and starvation over one window.
module axis_perf_cnt
    import axis_perf_cnt_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 32,
    parameter bit REG_SLICE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [CNT_WIDTH-1:0]  cnt_limit,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CNT_WIDTH-1:0]  data_cnt,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  starve_cnt,
    output logic                  done
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    generate
        if (REG_SLICE) begin : g_slice
            axis_perf_cnt_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .s_valid (s_axis_tvalid),
                .s_ready (s_axis_tready),
                .s_data  (s_axis_tdata),
                .m_valid (m_axis_tvalid),
                .m_ready (m_axis_tready),
                .m_data  (m_axis_tdata)
            );
        end else begin : g_bypass
            assign m_axis_tvalid = s_axis_tvalid;
            assign m_axis_tdata  = s_axis_tdata;
            assign s_axis_tready = m_axis_tready;
        end
    endgenerate

    state_t               state;
    logic [CNT_WIDTH-1:0] lim;
    logic                 fire;
    logic [CNT_WIDTH-1:0] data_inc;

    assign fire     = m_axis_tvalid && m_axis_tready;
    assign data_inc = sat_inc(data_cnt);

    // Measurement window, observed on the downstream handshake
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= ST_IDLE;
            lim        <= '0;
            data_cnt   <= '0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            starve_cnt <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        lim      <= cnt_limit;
                        data_cnt <= CNT_WIDTH'(1);
                        if (cnt_limit <= CNT_WIDTH'(1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (m_axis_tvalid && !m_axis_tready) stall_cnt <= sat_inc(stall_cnt);
                    if (!m_axis_tvalid) starve_cnt <= sat_inc(starve_cnt);
                    if (fire) begin
                        data_cnt <= data_inc;
                        if (data_inc == lim) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_perf_cnt.sv
// Directed and randomised checks of axis_perf_cnt in bypass, skid-buffer and narrow-counter builds.
module tb_axis_perf_cnt;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         clear0 = 1'b0, s_valid0 = 1'b0, m_ready0 = 1'b1;
    logic [31:0]  limit0 = '0;
    logic [127:0] s_data0 = '0;
    logic         s_ready0, m_valid0, done0;
    logic [127:0] m_data0;
    logic [31:0]  dc0, cc0, sc0, vc0;

    logic         clear1 = 1'b0, s_valid1 = 1'b0, m_ready1 = 1'b1;
    logic [31:0]  limit1 = '0;
    logic [31:0]  s_data1 = '0;
    logic         s_ready1, m_valid1, done1;
    logic [31:0]  m_data1;
    logic [31:0]  dc1, cc1, sc1, vc1;

    logic         clear2 = 1'b0, s_valid2 = 1'b0, m_ready2 = 1'b1;
    logic [2:0]   limit2 = '0;
    logic [7:0]   s_data2 = '0;
    logic         s_ready2, m_valid2, done2;
    logic [7:0]   m_data2;
    logic [2:0]   dc2, cc2, sc2, vc2;

    axis_perf_cnt #(.DATA_WIDTH(128), .CNT_WIDTH(32), .REG_SLICE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear0), .cnt_limit(limit0),
        .s_axis_tvalid(s_valid0), .s_axis_tready(s_ready0), .s_axis_tdata(s_data0),
        .m_axis_tvalid(m_valid0), .m_axis_tready(m_ready0), .m_axis_tdata(m_data0),
        .data_cnt(dc0), .cycle_cnt(cc0), .stall_cnt(sc0), .starve_cnt(vc0), .done(done0));

    axis_perf_cnt #(.DATA_WIDTH(32), .CNT_WIDTH(32), .REG_SLICE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear1), .cnt_limit(limit1),
        .s_axis_tvalid(s_valid1), .s_axis_tready(s_ready1), .s_axis_tdata(s_data1),
        .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready1), .m_axis_tdata(m_data1),
        .data_cnt(dc1), .cycle_cnt(cc1), .stall_cnt(sc1), .starve_cnt(vc1), .done(done1));

    axis_perf_cnt #(.DATA_WIDTH(8), .CNT_WIDTH(3), .REG_SLICE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .cnt_limit(limit2),
        .s_axis_tvalid(s_valid2), .s_axis_tready(s_ready2), .s_axis_tdata(s_data2),
        .m_axis_tvalid(m_valid2), .m_axis_tready(m_ready2), .m_axis_tdata(m_data2),
        .data_cnt(dc2), .cycle_cnt(cc2), .stall_cnt(sc2), .starve_cnt(vc2), .done(done2));

    int total = 0;
    int bad = 0;
    int seq0 = 0;
    int ms, md, mc, mst, msv;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic r, input int n);
        for (int k = 0; k < n; k++) begin
            s_valid0 = v;
            m_ready0 = r;
            s_data0  = 128'(seq0);
            cyc();
            if (v && r) seq0++;
        end
        s_valid0 = 1'b0;
        m_ready0 = 1'b1;
    endtask

    task automatic clr0();
        clear0 = 1'b1;
        cyc();
        clear0 = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int n);
        return {16'(n) ^ 16'hC0DE, 16'(n)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_dc0", 128'(dc0), 128'd0);
        chk("rst_cc0", 128'(cc0), 128'd0);
        chk("rst_done0", 128'(done0), 128'd0);
        chk("rst_mvalid1", 128'(m_valid1), 128'd0);
        chk("rst_sready1", 128'(s_ready1), 128'd1);

        // back-to-back, limit 8
        limit0 = 32'd8;
        for (int i = 0; i < 8; i++) begin
            s_valid0 = 1'b1;
            m_ready0 = 1'b1;
            s_data0  = {4{32'hA000_0000 + 32'(i)}};
            #1;
            chk("a_data", m_data0, {4{32'hA000_0000 + 32'(i)}});
            chk("a_mvalid", 128'(m_valid0), 128'd1);
            chk("a_sready", 128'(s_ready0), 128'd1);
            cyc();
        end
        s_valid0 = 1'b0;
        chk("a_dc", 128'(dc0), 128'd8);
        chk("a_cc", 128'(cc0), 128'd7);
        chk("a_stall", 128'(sc0), 128'd0);
        chk("a_starve", 128'(vc0), 128'd0);
        chk("a_done", 128'(done0), 128'd1);

        // backpressure
        clr0();
        chk("clr_dc", 128'(dc0), 128'd0);
        chk("clr_done", 128'(done0), 128'd0);
        limit0 = 32'd4;
        drive0(1'b1, 1'b1, 2);
        drive0(1'b1, 1'b0, 3);
        drive0(1'b1, 1'b1, 2);
        chk("b_cc", 128'(cc0), 128'd6);
        chk("b_stall", 128'(sc0), 128'd3);
        chk("b_starve", 128'(vc0), 128'd0);
        chk("b_done", 128'(done0), 128'd1);

        // source gaps
        clr0();
        limit0 = 32'd4;
        drive0(1'b1, 1'b1, 1);
        repeat (3) begin
            drive0(1'b0, 1'b1, 2);
            drive0(1'b1, 1'b1, 1);
        end
        chk("c_cc", 128'(cc0), 128'd9);
        chk("c_starve", 128'(vc0), 128'd6);
        chk("c_stall", 128'(sc0), 128'd0);
        chk("c_dc", 128'(dc0), 128'd4);

        // limit 1, then traffic after done is not counted
        clr0();
        limit0 = 32'd1;
        drive0(1'b1, 1'b1, 1);
        chk("d1_done", 128'(done0), 128'd1);
        chk("d1_dc", 128'(dc0), 128'd1);
        drive0(1'b1, 1'b1, 3);
        chk("d1_frozen_dc", 128'(dc0), 128'd1);
        chk("d1_frozen_cc", 128'(cc0), 128'd0);

        // limit 0
        clr0();
        limit0 = 32'd0;
        drive0(1'b1, 1'b1, 1);
        chk("d0_done", 128'(done0), 128'd1);
        chk("d0_dc", 128'(dc0), 128'd1);
        chk("d0_cc", 128'(cc0), 128'd0);

        // clear coincident with a beat, then limit change mid-window
        clr0();
        limit0 = 32'd3;
        clear0 = 1'b1; s_valid0 = 1'b1; m_ready0 = 1'b1;
        cyc();
        clear0 = 1'b0; s_valid0 = 1'b0;
        chk("e_dc", 128'(dc0), 128'd0);
        chk("e_done", 128'(done0), 128'd0);
        drive0(1'b1, 1'b1, 1);
        chk("e_open_dc", 128'(dc0), 128'd1);
        drive0(1'b0, 1'b1, 1);
        limit0 = 32'd2;
        drive0(1'b1, 1'b1, 1);
        chk("e_limchg_done", 128'(done0), 128'd0);
        drive0(1'b1, 1'b1, 1);
        chk("e_dc3", 128'(dc0), 128'd3);
        chk("e_done3", 128'(done0), 128'd1);
        chk("e_cc3", 128'(cc0), 128'd3);
        chk("e_starve", 128'(vc0), 128'd1);

        // counter saturation on a 3-bit build
        limit2 = 3'd7; s_valid2 = 1'b1; m_ready2 = 1'b1; s_data2 = 8'h11;
        cyc();
        m_ready2 = 1'b0;
        repeat (10) cyc();
        chk("s_cc", 128'(cc2), 128'd7);
        chk("s_stall", 128'(sc2), 128'd7);
        chk("s_starve", 128'(vc2), 128'd0);
        chk("s_sready", 128'(s_ready2), 128'd0);
        chk("s_mvalid", 128'(m_valid2), 128'd1);
        chk("s_mdata", 128'(m_data2), 128'h11);
        m_ready2 = 1'b1;
        repeat (6) cyc();
        chk("s_dc", 128'(dc2), 128'd7);
        chk("s_done", 128'(done2), 128'd1);
        s_valid2 = 1'b0;

        // reset mid-window; dut1 skid buffer filled then discarded
        clr0();
        limit0 = 32'd100;
        m_ready1 = 1'b0; s_valid1 = 1'b1; s_data1 = 32'h5555_0000;
        drive0(1'b1, 1'b1, 5);
        chk("f_dc5", 128'(dc0), 128'd5);
        chk("f_full_sready1", 128'(s_ready1), 128'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0; s_valid1 = 1'b0; m_ready1 = 1'b1;
        chk("f_rst_dc", 128'(dc0), 128'd0);
        chk("f_rst_cc", 128'(cc0), 128'd0);
        chk("f_rst_done", 128'(done0), 128'd0);
        chk("f_rst_mvalid1", 128'(m_valid1), 128'd0);
        chk("f_rst_sready1", 128'(s_ready1), 128'd1);
        limit0 = 32'd3;
        drive0(1'b1, 1'b1, 3);
        chk("f_dc3", 128'(dc0), 128'd3);
        chk("f_done", 128'(done0), 128'd1);
        chk("f_cc", 128'(cc0), 128'd2);

        // skid buffer: random valid/ready, 1000 beats
        limit1 = 32'd1000;
        ms = 0; md = 0; mc = 0; mst = 0; msv = 0;
        fork
            begin : src
                int i;
                int budget;
                logic acc;
                i = 0; budget = 0;
                while (i < 1000 && budget < 20000) begin
                    if (!s_valid1) s_valid1 = ($urandom_range(0, 3) != 0);
                    s_data1 = pat(i);
                    acc = s_valid1 && s_ready1;
                    cyc();
                    budget++;
                    if (acc) begin
                        i++;
                        s_valid1 = 1'b0;
                    end
                end
                s_valid1 = 1'b0;
                chk("r_src_budget", 128'(i), 128'd1000);
            end
            begin : sink
                int j;
                int budget;
                logic v, r, f;
                j = 0; budget = 0;
                while (j < 1000 && budget < 20000) begin
                    m_ready1 = ($urandom_range(0, 3) != 0);
                    v = m_valid1; r = m_ready1; f = v && r;
                    if (f) begin
                        chk("r_data", 128'(m_data1), 128'(pat(j)));
                        j++;
                    end
                    if (ms == 1) begin
                        mc++;
                        if (v && !r) mst++;
                        if (!v) msv++;
                        if (f) begin
                            md++;
                            if (md == 1000) ms = 2;
                        end
                    end else if (ms == 0 && f) begin
                        md = 1;
                        ms = 1;
                    end
                    cyc();
                    budget++;
                end
                m_ready1 = 1'b1;
                chk("r_sink_budget", 128'(j), 128'd1000);
            end
        join
        chk("r_dc", 128'(dc1), 128'd1000);
        chk("r_done", 128'(done1), 128'd1);
        chk("r_cc", 128'(cc1), 128'(mc));
        chk("r_stall", 128'(sc1), 128'(mst));
        chk("r_starve", 128'(vc1), 128'(msv));
        chk("r_invariant", 128'(sc1 + vc1 + dc1 - 32'd1), 128'(cc1));

        // skid buffer: no bubbles, then fill and drain in order
        cyc(); cyc();
        for (int k = 0; k < 4; k++) begin
            s_valid1 = 1'b1;
            s_data1  = 32'hB0 + 32'(k);
            cyc();
            chk("t_mvalid", 128'(m_valid1), 128'd1);
            chk("t_mdata", 128'(m_data1), 128'(32'hB0 + 32'(k)));
            chk("t_sready", 128'(s_ready1), 128'd1);
        end
        s_valid1 = 1'b0;
        cyc();
        chk("t_drained", 128'(m_valid1), 128'd0);
        m_ready1 = 1'b0; s_valid1 = 1'b1; s_data1 = 32'hA;
        cyc();
        s_data1 = 32'hB;
        cyc();
        chk("k_full_sready", 128'(s_ready1), 128'd0);
        chk("k_head", 128'(m_data1), 128'hA);
        s_data1 = 32'hC;
        m_ready1 = 1'b1;
        cyc();
        chk("k_second", 128'(m_data1), 128'hB);
        chk("k_sready_back", 128'(s_ready1), 128'd1);
        cyc();
        s_valid1 = 1'b0;
        chk("k_third", 128'(m_data1), 128'hC);
        chk("k_third_valid", 128'(m_valid1), 128'd1);
        cyc();
        chk("k_empty", 128'(m_valid1), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
